// File: rtl/adc_expansor_if.sv
// Bundles the ADC serial link, conversion request and expanded-sample result.
// master = requester/ADC side, slave = adc_expansor.
interface adc_expansor_if;
  logic        inicio;
  logic        sdata;
  logic        cs_n;
  logic        sclk;
  logic [28:0] dato_expandido;
  logic        listo;
  logic        ocupado;
  logic        error_trama;

  modport master (
    output inicio, sdata,
    input  cs_n, sclk, dato_expandido, listo, ocupado, error_trama
  );

  modport slave (
    input  inicio, sdata,
    output cs_n, sclk, dato_expandido, listo, ocupado, error_trama
  );
endinterface

// File: rtl/adc_expansor.sv
// Reads one 16-bit frame (4 leading zeros + 12-bit offset-binary code) from a serial ADC
// and expands it to Q10.18 two's complement; listo pulses 32*CLK_DIV+1 clks after inicio.
module adc_expansor #(
  parameter int CLK_DIV = 4
) (
  input  logic          clk,
  input  logic          reset,
  adc_expansor_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bits_q, bits_d;
  logic [15:0] shift_q, shift_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        listo_q, listo_d;
  logic        ocupado_q, ocupado_d;
  logic        err_q, err_d;
  logic [28:0] dato_q, dato_d;
  logic [11:0] code_t;

  // Flipping the MSB turns offset binary into two's complement.
  assign code_t = {~shift_q[11], shift_q[10:0]};

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bits_d    = bits_q;
    shift_d   = shift_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    listo_d   = 1'b0;
    ocupado_d = ocupado_q;
    err_d     = err_q;
    dato_d    = dato_q;
    case (state_q)
      S_IDLE: begin
        if (bus.inicio) begin
          state_d   = S_XFER;
          cs_n_d    = 1'b0;
          ocupado_d = 1'b1;
          sclk_d    = 1'b1;
          div_d     = 8'd0;
          bits_d    = 5'd0;
          shift_d   = 16'd0;
        end
      end
      S_XFER: begin
        if (bits_q == 5'd16) begin
          state_d = S_FIN;
          cs_n_d  = 1'b1;
          sclk_d  = 1'b1;
          listo_d = 1'b1;
          err_d   = |shift_q[15:12];
          dato_d  = {{11{code_t[11]}}, code_t, 6'b0};
        end else if (div_q == DIV_LAST) begin
          div_d  = 8'd0;
          sclk_d = ~sclk_q;
          // Sample on the edge that drives sclk high; the ADC updates on the fall.
          if (!sclk_q) begin
            shift_d = {shift_q[14:0], bus.sdata};
            bits_d  = bits_q + 5'd1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_FIN: begin
        state_d   = S_IDLE;
        ocupado_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_q     <= 8'd0;
      bits_q    <= 5'd0;
      shift_q   <= 16'd0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      listo_q   <= 1'b0;
      ocupado_q <= 1'b0;
      err_q     <= 1'b0;
      dato_q    <= 29'd0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bits_q    <= bits_d;
      shift_q   <= shift_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      listo_q   <= listo_d;
      ocupado_q <= ocupado_d;
      err_q     <= err_d;
      dato_q    <= dato_d;
    end
  end

  assign bus.cs_n           = cs_n_q;
  assign bus.sclk           = sclk_q;
  assign bus.listo          = listo_q;
  assign bus.ocupado        = ocupado_q;
  assign bus.error_trama    = err_q;
  assign bus.dato_expandido = dato_q;

endmodule

// File: tb/tb_adc_expansor.sv
// Self-checking bench for adc_expansor with CLK_DIV=4 and an ADC model shifting on sclk fall.
`timescale 1ns/1ps
module tb_adc_expansor;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  adc_expansor_if bus();
  adc_expansor #(.CLK_DIV(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ADC model: presents the next frame bit on every sclk fall while selected.
  logic [15:0] adc_word = 16'd0;
  logic        sdata_r = 1'b0;
  int          idx = 0;
  assign bus.sdata = sdata_r;
  always @(negedge bus.sclk or posedge bus.cs_n) begin
    if (bus.cs_n) idx = 0;
    else begin
      if (idx < 16) sdata_r = adc_word[15-idx];
      idx++;
    end
  end

  // Scoreboard: expectations pushed at frame start, popped on each listo.
  typedef struct {
    logic [28:0] dato;
    logic        err;
    int          at;
  } exp_t;
  exp_t sb[$];

  int   listo_cnt = 0;
  int   sclk_edges = 0;
  int   csn_low = 0;
  logic sclk_prev = 1'b1;
  exp_t e;
  always @(negedge clk) begin
    if (bus.sclk !== sclk_prev) sclk_edges++;
    sclk_prev = bus.sclk;
    if (bus.cs_n === 1'b0) csn_low++;
    if (bus.listo === 1'b1) begin
      listo_cnt++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_listo: got listo at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("listo_cycle", cyc, e.at);
        chk("dato", bus.dato_expandido, e.dato);
        chk("error_trama", bus.error_trama, e.err);
        chk("ocupado_at_listo", bus.ocupado, 1);
        chk("cs_n_at_listo", bus.cs_n, 1);
      end
    end
  end

  typedef struct {
    logic [3:0]  lead;
    logic [11:0] code;
    logic [28:0] dato;
    logic        err;
  } vec_t;
  vec_t vecs[9];

  // Called #1 after a clk edge; inicio is accepted on the next edge.
  task automatic start_frame(input logic [15:0] w, input logic push, input logic [28:0] d,
                             input logic er, output int start);
    exp_t x;
    adc_word = w;
    bus.inicio = 1'b1;
    @(posedge clk);
    #1;
    bus.inicio = 1'b0;
    start = cyc;
    if (push) begin
      x.dato = d;
      x.err  = er;
      x.at   = start + 129;
      sb.push_back(x);
    end
  endtask

  task automatic wait_listo();
    int n = 0;
    while (bus.listo !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (bus.listo !== 1'b1) chk("listo_timeout", 32'(n), 0);
    @(negedge clk);
    chk("listo_after", bus.listo, 0);
    chk("ocupado_after", bus.ocupado, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, l0, e0, c0;
    vecs[0] = '{4'b0000, 12'h800, 29'h00000000, 1'b0};
    vecs[1] = '{4'b0000, 12'hFFF, 29'h0001FFC0, 1'b0};
    vecs[2] = '{4'b0000, 12'hA5C, 29'h00009700, 1'b0};
    vecs[3] = '{4'b0000, 12'h000, 29'h1FFE0000, 1'b0};
    vecs[4] = '{4'b0100, 12'h800, 29'h00000000, 1'b1};
    vecs[5] = '{4'b0000, 12'h7FF, 29'h1FFFFFC0, 1'b0};
    vecs[6] = '{4'b0000, 12'h801, 29'h00000040, 1'b0};
    vecs[7] = '{4'b1000, 12'hFFF, 29'h0001FFC0, 1'b1};
    vecs[8] = '{4'b0001, 12'h000, 29'h1FFE0000, 1'b1};

    bus.inicio = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", bus.cs_n, 1);
    chk("rst_sclk", bus.sclk, 1);
    chk("rst_listo", bus.listo, 0);
    chk("rst_ocupado", bus.ocupado, 0);
    chk("rst_error", bus.error_trama, 0);
    chk("rst_dato", bus.dato_expandido, 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      start_frame({vecs[i].lead, vecs[i].code}, 1'b1, vecs[i].dato, vecs[i].err, s);
      #1;
      chk("ocupado_start", bus.ocupado, 1);
      chk("cs_n_start", bus.cs_n, 0);
      wait_listo();
      repeat (5) @(posedge clk);
      #1;
      chk("hold_dato", bus.dato_expandido, vecs[i].dato);
      chk("hold_error", bus.error_trama, vecs[i].err);
      chk("code_roundtrip", {~bus.dato_expandido[17], bus.dato_expandido[16:6]}, vecs[i].code);
    end

    // inicio during TRANSFER (cycle 10) and at the FIN edge (cycle 129) must be ignored.
    l0 = listo_cnt; e0 = sclk_edges; c0 = csn_low;
    start_frame(16'h0A5C, 1'b1, 29'h00009700, 1'b0, s);
    wait_until(s + 9);
    bus.inicio = 1'b1;
    @(posedge clk); #1;
    bus.inicio = 1'b0;
    wait_until(s + 128);
    bus.inicio = 1'b1;
    @(posedge clk); #1;
    bus.inicio = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("single_listo", listo_cnt - l0, 1);
    chk("sclk_edges", sclk_edges - e0, 32);
    chk("cs_n_low_cycles", csn_low - c0, 129);
    chk("idle_ocupado", bus.ocupado, 0);

    // Reset at cycle 60 aborts the frame; a fresh request then completes normally.
    l0 = listo_cnt;
    start_frame(16'h0800, 1'b0, 29'd0, 1'b0, s);
    wait_until(s + 60);
    reset = 1'b1;
    #1;
    chk("abort_cs_n", bus.cs_n, 1);
    chk("abort_sclk", bus.sclk, 1);
    chk("abort_listo", bus.listo, 0);
    chk("abort_ocupado", bus.ocupado, 0);
    chk("abort_error", bus.error_trama, 0);
    chk("abort_dato", bus.dato_expandido, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("no_listo_after_abort", listo_cnt - l0, 0);
    start_frame(16'h0FFF, 1'b1, 29'h0001FFC0, 1'b0, s);
    wait_listo();
    chk("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
